// File: rtl/watch_pkg.sv
// watch_pkg: types and constants shared by the watch front-end and the mode FSM.
//   cmd_code_e : command tokens carried on cmd_code (CMD_NONE when nothing valid)
//   state_e    : states of the command arbiter
//   DEF_*      : default qualification / repeat timing at 100 MHz
//   pick_winner: fixed-priority selection CLEAR > MODE > SHIFT > INC > START
//   btn_of     : level of the button that belongs to a given command
package watch_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_CLEAR = 3'd1,
        CMD_MODE  = 3'd2,
        CMD_SHIFT = 3'd3,
        CMD_INC   = 3'd4,
        CMD_START = 3'd5
    } cmd_code_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_QUAL    = 3'd1,
        ST_ISSUE   = 3'd2,
        ST_REPEAT  = 3'd3,
        ST_RELEASE = 3'd4
    } state_e;

    localparam int unsigned DEF_HOLD_CYCLES   = 32'd15_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 32'd5_000_000;
    localparam int unsigned DEF_CNT_W         = 32'd32;

    // Bit positions inside the packed 5-bit button vector.
    localparam int unsigned BTN_N     = 32'd5;
    localparam int unsigned BTN_CLEAR = 32'd0;
    localparam int unsigned BTN_MODE  = 32'd1;
    localparam int unsigned BTN_SHIFT = 32'd2;
    localparam int unsigned BTN_INC   = 32'd3;
    localparam int unsigned BTN_START = 32'd4;

    function automatic cmd_code_e pick_winner(input logic [4:0] btns);
        cmd_code_e w;
        if (btns[BTN_CLEAR]) begin
            w = CMD_CLEAR;
        end else if (btns[BTN_MODE]) begin
            w = CMD_MODE;
        end else if (btns[BTN_SHIFT]) begin
            w = CMD_SHIFT;
        end else if (btns[BTN_INC]) begin
            w = CMD_INC;
        end else if (btns[BTN_START]) begin
            w = CMD_START;
        end else begin
            w = CMD_NONE;
        end
        return w;
    endfunction

    function automatic logic btn_of(input cmd_code_e cmd, input logic [4:0] btns);
        logic b;
        case (cmd)
            CMD_CLEAR: b = btns[BTN_CLEAR];
            CMD_MODE:  b = btns[BTN_MODE];
            CMD_SHIFT: b = btns[BTN_SHIFT];
            CMD_INC:   b = btns[BTN_INC];
            CMD_START: b = btns[BTN_START];
            default:   b = 1'b0;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/watch_cmd_arbiter_btn_sync.sv
// btn_sync: WIDTH-bit two-flop synchroniser for asynchronous push-buttons.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages to 0
//   d     : raw asynchronous inputs
//   q     : inputs synchronised to clk (two-cycle latency)
module btn_sync #(
    parameter int unsigned WIDTH = 32'd5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; only the second stage is used downstream.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= {WIDTH{1'b0}};
            sync_q <= {WIDTH{1'b0}};
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/watch_cmd_arbiter.sv
// watch_cmd_arbiter: turns the five raw watch buttons into single, hold-qualified,
// prioritised command tokens with INC auto-repeat, delivered over valid/ready.
//   clk        : 100 MHz system clock
//   reset      : asynchronous active-low reset
//   btn_*      : raw buttons (clear, mode, shift, inc, start), asynchronous
//   cmd_ready  : consumer accepts the presented command this cycle
//   cmd_valid  : command presented, held until accepted
//   cmd_code   : watch_pkg::cmd_code_e value, CMD_NONE when cmd_valid is low
//   busy       : arbiter is not in IDLE
module watch_cmd_arbiter
    import watch_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_clear,
    input  logic       btn_mode,
    input  logic       btn_shift,
    input  logic       btn_inc,
    input  logic       btn_start,
    input  logic       cmd_ready,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    output logic       busy
);

    localparam logic [CNT_W-1:0] HOLD_LIM   = CNT_W'(HOLD_CYCLES);
    localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};

    logic [4:0]       btn_raw_s;
    logic [4:0]       btn_s;
    logic             handshake_s;

    state_e           state_q, state_d;
    cmd_code_e        winner_q, winner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cmd_valid_q, cmd_valid_d;
    cmd_code_e        cmd_code_q, cmd_code_d;
    logic             busy_q, busy_d;

    assign btn_raw_s = {btn_start, btn_inc, btn_shift, btn_mode, btn_clear};

    btn_sync #(
        .WIDTH (BTN_N)
    ) u_btn_sync (
        .clk   (clk),
        .rst_n (reset),
        .d     (btn_raw_s),
        .q     (btn_s)
    );

    assign handshake_s = cmd_valid_q && cmd_ready;

    // State, counter, winner and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            winner_q    <= CMD_NONE;
            cnt_q       <= CNT_ZERO;
            cmd_valid_q <= 1'b0;
            cmd_code_q  <= CMD_NONE;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            cnt_q       <= cnt_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_code_q  <= cmd_code_d;
            busy_q      <= busy_d;
        end
    end

    // Next-state logic: qualify the winner, issue, auto-repeat INC, wait for release.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|btn_s) begin
                    winner_d = pick_winner(btn_s);
                    cnt_d    = CNT_ONE;
                    state_d  = ST_QUAL;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_QUAL: begin
                // Only the latched winner matters here; later presses never pre-empt it.
                if (!btn_of(winner_q, btn_s)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == HOLD_LIM) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_ISSUE: begin
                if (handshake_s) begin
                    if ((winner_q == CMD_INC) && btn_s[BTN_INC]) begin
                        cnt_d   = CNT_ONE;
                        state_d = ST_REPEAT;
                    end else begin
                        state_d = ST_RELEASE;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_REPEAT: begin
                if (!btn_s[BTN_INC]) begin
                    state_d = ST_RELEASE;
                end else if (cnt_q == REPEAT_LIM) begin
                    state_d = ST_ISSUE;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            ST_RELEASE: begin
                // Every button must be up so a chord never produces a second command.
                if (btn_s == 5'b00000) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                winner_d = CMD_NONE;
                cnt_d    = CNT_ZERO;
            end
        endcase
    end

    // Output logic: valid rises one cycle after entering ISSUE and drops on the accepting edge.
    always_comb begin
        cmd_valid_d = (state_q == ST_ISSUE) && !handshake_s;
        if (cmd_valid_d) begin
            cmd_code_d = winner_q;
        end else begin
            cmd_code_d = CMD_NONE;
        end
        busy_d = (state_d != ST_IDLE);
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_code  = cmd_code_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_watch_cmd_arbiter.sv
module tb_watch_cmd_arbiter;
    import watch_pkg::*;

    localparam int unsigned HOLD = 32'd4;
    localparam int unsigned REP  = 32'd3;

    logic       clk = 1'b0;
    logic       reset;
    logic       btn_clear, btn_mode, btn_shift, btn_inc, btn_start;
    logic       cmd_ready;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    int         xfers = 0;
    logic [2:0] sb_q[$];
    logic [2:0] sb_exp;

    always #5 clk = ~clk;

    watch_cmd_arbiter #(
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REP),
        .CNT_W         (32'd32)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_clear (btn_clear),
        .btn_mode  (btn_mode),
        .btn_shift (btn_shift),
        .btn_inc   (btn_inc),
        .btn_start (btn_start),
        .cmd_ready (cmd_ready),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Sample n cycles (index i = after edge i); drop all buttons after sampling index drop_at.
    task automatic observe(input int n, input int drop_at, output logic [63:0] seen);
        seen = 64'd0;
        for (int i = 0; i < n; i++) begin
            tick(1);
            if (cmd_valid === 1'b1) seen[i] = 1'b1;
            if (i == drop_at) begin
                btn_clear = 1'b0; btn_mode = 1'b0; btn_shift = 1'b0;
                btn_inc   = 1'b0; btn_start = 1'b0;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b0) break;
            tick(1);
        end
        chk(tag, busy, 64'd0);
    endtask

    task automatic wait_valid(input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (cmd_valid === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk(tag, found, 64'd1);
    endtask

    // Scoreboard: every transfer pops the next expected code.
    always @(negedge clk) begin
        if (reset === 1'b1 && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            xfers++;
            sb_exp = (sb_q.size() > 0) ? sb_q.pop_front() : 3'd0;
            chk("sb_code", cmd_code, sb_exp);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] seen;
        logic [63:0] exp_mask;
        logic        stable;
        int          x0;

        btn_clear = 1'b0; btn_mode = 1'b0; btn_shift = 1'b0;
        btn_inc = 1'b0; btn_start = 1'b0; cmd_ready = 1'b0;
        reset = 1'b1;
        #2 reset = 1'b0;
        #2;
        chk("rst_valid", cmd_valid, 64'd0);
        chk("rst_code", cmd_code, 64'd0);
        chk("rst_busy", busy, 64'd0);
        chk("rst_state", dut.state_q, 64'(ST_IDLE));
        chk("rst_cnt", dut.cnt_q, 64'd0);
        tick(2);
        reset = 1'b1;
        tick(2);

        // Tap shorter than the hold time.
        btn_mode = 1'b1;
        tick(3);
        btn_mode = 1'b0;
        observe(15, -1, seen);
        chk("tap_novalid", seen, 64'd0);
        chk("tap_busy", busy, 64'd0);
        chk("tap_state", dut.state_q, 64'(ST_IDLE));

        // Qualified SHIFT press.
        cmd_ready = 1'b1;
        sb_q.push_back(3'd3);
        btn_shift = 1'b1;
        observe(20, -1, seen);
        exp_mask = 64'd1 << 7;
        chk("shift_mask", seen, exp_mask);
        btn_shift = 1'b0;
        wait_idle("shift_idle");

        // INC + CLEAR together: CLEAR wins, no repeat; MODE during chord ignored.
        sb_q.push_back(3'd1);
        btn_inc = 1'b1; btn_clear = 1'b1;
        observe(20, -1, seen);
        chk("chord_mask", seen, exp_mask);
        btn_mode = 1'b1;
        observe(10, -1, seen);
        chk("chord_mode_none", seen, 64'd0);
        btn_inc = 1'b0; btn_clear = 1'b0; btn_mode = 1'b0;
        observe(15, -1, seen);
        chk("chord_release_none", seen, 64'd0);
        wait_idle("chord_idle");

        // Backpressure on START.
        cmd_ready = 1'b0;
        btn_start = 1'b1;
        wait_valid("bp_valid");
        btn_start = 1'b0;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            if (!(cmd_valid === 1'b1 && cmd_code === 3'd5)) stable = 1'b0;
        end
        chk("bp_stable", stable, 64'd1);
        x0 = xfers;
        sb_q.push_back(3'd5);
        cmd_ready = 1'b1;
        tick(1);
        chk("bp_drop", cmd_valid, 64'd0);
        tick(10);
        chk("bp_one_xfer", xfers - x0, 64'd1);
        wait_idle("bp_idle");

        // INC auto-repeat: released so that exactly three INCs are issued.
        repeat (3) sb_q.push_back(3'd4);
        btn_inc = 1'b1;
        observe(36, 16, seen);
        exp_mask = (64'd1 << 7) | (64'd1 << 12) | (64'd1 << 17);
        chk("rep_mask", seen, exp_mask);
        wait_idle("rep_idle");
        chk("rep_sb_empty", sb_q.size(), 64'd0);

        // Reset while a command is pending: it is discarded.
        cmd_ready = 1'b0;
        btn_start = 1'b1;
        wait_valid("ri_valid");
        reset = 1'b0;
        #1;
        chk("ri_valid0", cmd_valid, 64'd0);
        chk("ri_code0", cmd_code, 64'd0);
        chk("ri_busy0", busy, 64'd0);
        btn_start = 1'b0;
        tick(2);
        reset = 1'b1;
        cmd_ready = 1'b1;
        x0 = xfers;
        observe(15, -1, seen);
        chk("ri_no_replay", seen, 64'd0);
        chk("ri_no_xfer", xfers - x0, 64'd0);

        // Reset during QUAL with INC still held: full requalification.
        btn_inc = 1'b1;
        tick(4);
        chk("rq_busy", busy, 64'd1);
        reset = 1'b0;
        #1;
        chk("rq_valid0", cmd_valid, 64'd0);
        chk("rq_code0", cmd_code, 64'd0);
        chk("rq_busy0", busy, 64'd0);
        tick(2);
        reset = 1'b1;
        sb_q.push_back(3'd4);
        observe(14, 7, seen);
        exp_mask = 64'd1 << 7;
        chk("rq_mask", seen, exp_mask);
        wait_idle("rq_idle");
        chk("end_sb_empty", sb_q.size(), 64'd0);
        chk("end_xfers", xfers, 64'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/watch_cmd_arbiter.md
# watch_cmd_arbiter

Front-end controller that turns the five raw push-buttons of the digital watch (clear, mode, edit-shift, increment, start/stop) into single, qualified, prioritised command tokens for the watch mode FSM. It synchronises the buttons and applies the hold-time qualification that the mode FSM otherwise performs per button. It arbitrates simultaneous presses, auto-repeats the increment button, and delivers each command over a valid/ready handshake. It sits between the board pins and the clock/edit/timer sequencer.

## Interface
- HOLD_CYCLES, 15_000_000: clk cycles a button must stay high before its command issues.
- REPEAT_CYCLES, 5_000_000: auto-repeat period for a held increment button after its first command.
- CNT_W, 32: qualification counter width; must satisfy 2^CNT_W > max(HOLD_CYCLES, REPEAT_CYCLES).
- clk  in  1  system clock, 100 MHz.
- reset  in  1  asynchronous, active-low reset.
- btn_clear  in  1  raw clear button, asynchronous to clk.
- btn_mode  in  1  raw mode button.
- btn_shift  in  1  raw edit-shift button.
- btn_inc  in  1  raw increment button.
- btn_start  in  1  raw start/stop button.
- cmd_ready  in  1  mode FSM accepts the command this cycle.
- cmd_valid  out  1  a command is presented; held until accepted.
- cmd_code  out  3  command code: 1 CLEAR, 2 MODE, 3 SHIFT, 4 INC, 5 START, 0 when invalid.
- busy  out  1  high in any state other than IDLE.

## Operation
- Each button passes through a 2-flop synchroniser, which is reset to 0.
- States: IDLE, QUAL, ISSUE, REPEAT, RELEASE.
- IDLE, any synchronised button high:
  - Latch the winner by fixed priority CLEAR > MODE > SHIFT > INC > START.
  - Set cnt to 1 and go to QUAL.
- QUAL:
  - Winner low: go to IDLE; no command, no side effects.
  - Else cnt == HOLD_CYCLES: go to ISSUE.
  - Else cnt++.
  - Other buttons are ignored in this state; they do not pre-empt the winner, even a higher-priority one.
- ISSUE:
  - cmd_valid = 1 and cmd_code = winner code, both registered and stable until handshake.
  - On cmd_valid && cmd_ready, if winner is INC and btn_inc is still high: set cnt to 1 and go to REPEAT.
  - Otherwise go to RELEASE.
  - A button released while in ISSUE does not withdraw the command.
- REPEAT:
  - btn_inc low: go to RELEASE.
  - cnt == REPEAT_CYCLES: go to ISSUE, which issues another INC.
  - Else cnt++.
- RELEASE: wait until all five synchronised buttons are low, then go to IDLE. This guarantees one command per press (plus INC repeats) and suppresses chords.
- Reset asserted mid-operation: immediately enter IDLE, clear cnt and the synchronisers, and drop cmd_valid. A pending command is discarded; it is never replayed.
- Counter arithmetic is unsigned CNT_W bits. cnt never exceeds max(HOLD_CYCLES, REPEAT_CYCLES), so there is no wrap.

## Timing
- Reset values: cmd_valid = 0, cmd_code = 0, busy = 0, state = IDLE, cnt = 0.
- Latency, with a button first sampled high at edge 0 and held: cmd_valid is high after edge HOLD_CYCLES+3.
- Minimum qualifying press is HOLD_CYCLES+1 consecutive samples high at the synchroniser output.
- Handshake: the transfer occurs on the edge where cmd_valid && cmd_ready.
  - cmd_valid deasserts, or re-arms via REPEAT, on the following cycle.
  - cmd_ready held high gives exactly one transfer per ISSUE visit.
  - cmd_ready is ignored when cmd_valid = 0.
- INC repeat interval with cmd_ready tied high: REPEAT_CYCLES+2 cycles between successive accepted INC commands (1 accept, REPEAT_CYCLES count, 1 re-entry).
- Simultaneous rising of several buttons in the same synchronised cycle: the priority winner alone is qualified.

## Structure
- Shared package watch_pkg holds:
  - the cmd_code enum (CMD_NONE=0 … CMD_START=5), shared with the mode FSM;
  - the state enum;
  - default HOLD_CYCLES / REPEAT_CYCLES constants.
- One sub-module is natural: btn_sync, a 5-bit-wide 2-flop synchroniser with async active-low reset, instantiated once.

## Test plan
Bench uses HOLD_CYCLES=4, REPEAT_CYCLES=3.
- Tap: btn_mode high for 3 cycles only -> cmd_valid never asserts; busy returns to 0 and state to IDLE.
- Qualified press: btn_shift held 20 cycles, cmd_ready=1 -> cmd_valid high after edge 7 for exactly one cycle, cmd_code=3; no second command before release.
- Priority and chord: btn_inc and btn_clear rise together and are held 20 cycles -> one command, code 1. Then btn_mode pressed while btn_clear is still held -> no MODE command until all buttons are released.
- Backpressure: btn_start qualified with cmd_ready=0 for 10 cycles, button released meanwhile -> cmd_valid/code 5 stay stable; exactly one transfer when cmd_ready rises.
- Auto-repeat: btn_inc held 30 cycles, cmd_ready=1 -> first INC after edge 7, then an INC every 5 cycles while held; none after release.
- Reset mid-QUAL and mid-ISSUE: reset pulled low -> cmd_valid=0, cmd_code=0 and busy=0 on the same cycle. After reset releases with btn_inc still held, a fresh full HOLD_CYCLES qualification is required before any command.
